// File: rtl/hs_arb_pkg.sv
// Shared definitions for the handshake round-robin arbiter.
package hs_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_UP = 2'd1,
    ST_ACK_DN  = 2'd2
  } state_e;

  // Index width for a port count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hs_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate so the slot after the last
// winner is bit 0, take the lowest set bit, rotate the index back.
module rr_pick #(
  parameter int num_ports = 4,
  parameter int idx_width = 2
) (
  input  logic [num_ports-1:0] i_vec,
  input  logic [idx_width-1:0] i_last,
  output logic [idx_width-1:0] o_idx,
  output logic                 o_valid
);

  logic [idx_width-1:0] w_start;
  logic [num_ports-1:0] w_rot;
  logic [idx_width-1:0] w_off;
  logic [idx_width:0]   w_sum;

  // Search starts one past the previous winner, wrapping at the top port.
  assign w_start = (i_last >= idx_width'(num_ports - 1)) ? '0 : i_last + 1'b1;
  assign w_rot   = num_ports'({i_vec, i_vec} >> w_start);

  // Lowest set bit of the rotated vector is the closest eligible port.
  always_comb begin
    w_off = '0;
    for (int k = num_ports - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = idx_width'(k);
    end
  end

  assign w_sum   = {1'b0, w_start} + {1'b0, w_off};
  assign o_idx   = (w_sum >= (idx_width + 1)'(num_ports))
                   ? idx_width'(w_sum - (idx_width + 1)'(num_ports))
                   : w_sum[idx_width-1:0];
  assign o_valid = |i_vec;

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one upstream req/ack source among
// num_ports downstream req/ack requesters. One transfer in flight.
module hs_rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter int num_ports  = 4,
  parameter int data_width = 32,
  parameter int cnt_width  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [num_ports-1:0]           req_dn,
  output logic [num_ports-1:0]           ack_dn,
  output logic [data_width-1:0]          dout_dn,
  input  logic [num_ports-1:0]           port_en,
  output logic                           req_up,
  input  logic                           ack_up,
  input  logic [data_width-1:0]          din_up,
  output logic [idx_w(num_ports)-1:0]    grant_id,
  output logic                           busy,
  output logic [num_ports*cnt_width-1:0] xfer_count
);

  localparam int IDX_W = idx_w(num_ports);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  w_take;
  logic                  w_capture;
  logic                  r_req_up;
  logic [num_ports-1:0]  r_ack_dn;
  logic [data_width-1:0] r_dout;
  logic [IDX_W-1:0]      r_grant;
  logic [IDX_W-1:0]      w_win;
  logic                  w_win_vld;

  rr_pick #(
    .num_ports (num_ports),
    .idx_width (IDX_W)
  ) u_pick (
    .i_vec   (req_dn & port_en),
    .i_last  (r_grant),
    .o_idx   (w_win),
    .o_valid (w_win_vld)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state plus grant/capture strobes; requests are only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_take      = 1'b1;
          w_state_nxt = ST_WAIT_UP;
        end
      end
      ST_WAIT_UP: begin
        if (ack_up) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_ACK_DN;
        end
      end
      ST_ACK_DN: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Upstream request is high exactly while waiting, so it is low the cycle after ack_up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_req_up <= 1'b0;
    else      r_req_up <= (w_state_nxt == ST_WAIT_UP);
  end

  // Winner index is latched at grant and held until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_grant <= IDX_W'(num_ports - 1);
    else if (w_take) r_grant <= w_win;
  end

  // One-hot acknowledge to the committed winner for the single ACK_DN cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_ack_dn <= '0;
    else if (w_capture) r_ack_dn <= num_ports'(1) << r_grant;
    else                r_ack_dn <= '0;
  end

  // Captured upstream word, held until the next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_dout <= '0;
    else if (w_capture) r_dout <= din_up;
  end

  for (genvar g = 0; g < num_ports; g++) begin : g_cnt
    logic [cnt_width-1:0] r_cnt;

    // Completed transfers for this port, wrapping naturally.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                     r_cnt <= '0;
      else if (w_capture && (r_grant == IDX_W'(g))) r_cnt <= r_cnt + 1'b1;
    end

    assign xfer_count[g*cnt_width +: cnt_width] = r_cnt;
  end

  assign req_up   = r_req_up;
  assign ack_dn   = r_ack_dn;
  assign dout_dn  = r_dout;
  assign grant_id = r_grant;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Self-checking bench for hs_rr_arbiter with a req/ack source model.
module tb_hs_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req_dn = '0;
  logic [NP-1:0] ack_dn;
  logic [DW-1:0] dout_dn;
  logic [NP-1:0] port_en = '1;
  logic          req_up;
  logic          ack_up = 1'b0;
  logic [DW-1:0] din_up = '0;
  logic [1:0]    grant_id;
  logic          busy;
  logic [NP*CW-1:0] xfer_count;

  int checks = 0;
  int errors = 0;

  int            fail_rate = 0;
  int            stall_cnt = 0;
  bit            spur_req  = 1'b0;
  logic [DW-1:0] src_data  = '0;
  logic [DW-1:0] exp_data[$];
  int            exp_port[$];

  always #5 clk = ~clk;

  hs_rr_arbiter #(.num_ports(NP), .data_width(DW), .cnt_width(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_dn     (req_dn),
    .ack_dn     (ack_dn),
    .dout_dn    (dout_dn),
    .port_en    (port_en),
    .req_up     (req_up),
    .ack_up     (ack_up),
    .din_up     (din_up),
    .grant_id   (grant_id),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  // Upstream producer: acks a pending req_up, pushes each delivered word.
  always @(negedge clk) begin
    ack_up = 1'b0;
    if (spur_req) begin
      ack_up   = 1'b1;
      din_up   = 32'hDEAD_BEEF;
      spur_req = 1'b0;
    end else if (rst === 1'b1 && req_up === 1'b1) begin
      if (stall_cnt > 0) stall_cnt--;
      else if ($urandom_range(99) >= fail_rate) begin
        ack_up = 1'b1;
        din_up = src_data;
        exp_data.push_back(src_data);
        src_data++;
      end
    end
  end

  function automatic logic [CW-1:0] cnt(input int p);
    return xfer_count[p*CW +: CW];
  endfunction

  task automatic apply_reset;
    @(negedge clk);
    rst       = 1'b0;
    req_dn    = '0;
    port_en   = '1;
    fail_rate = 0;
    stall_cnt = 0;
    spur_req  = 1'b0;
    repeat (2) @(negedge clk);
    exp_data.delete();
    exp_port.delete();
    src_data = '0;
    rst      = 1'b1;
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ack_dn !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst     = 1'b0;
    req_dn  = '0;
    port_en = '1;
    #22;
    checks++; if (ack_dn !== 4'b0000)   begin errors++; $display("FAIL reset_ack_dn got=%b exp=0000", ack_dn); end
    checks++; if (dout_dn !== '0)       begin errors++; $display("FAIL reset_dout got=%h exp=0", dout_dn); end
    checks++; if (req_up !== 1'b0)      begin errors++; $display("FAIL reset_req_up got=%b exp=0", req_up); end
    checks++; if (grant_id !== 2'd3)    begin errors++; $display("FAIL reset_grant_id got=%0d exp=3", grant_id); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (xfer_count !== '0)    begin errors++; $display("FAIL reset_xfer_count got=%h exp=0", xfer_count); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic;
    bit ok;
    logic [DW-1:0] d;
    apply_reset();
    src_data = 32'h55;
    req_dn   = 4'b0100;
    @(negedge clk);
    checks++; if (req_up !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd2)
      begin errors++; $display("FAIL basic_grant req_up=%b busy=%b grant=%0d exp 1 1 2", req_up, busy, grant_id); end
    wait_ack(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout no ack_dn exp ack"); return; end
    d = (exp_data.size() > 0) ? exp_data.pop_front() : 'x;
    req_dn = '0;
    if (ack_dn !== 4'b0100) begin errors++; $display("FAIL basic_ack got=%b exp=0100", ack_dn); end
    checks++; if (dout_dn !== d)     begin errors++; $display("FAIL basic_dout got=%h exp=%h", dout_dn, d); end
    checks++; if (req_up !== 1'b0)   begin errors++; $display("FAIL basic_req_up_after_ack got=%b exp=0", req_up); end
    checks++; if (cnt(2) !== 32'd1)  begin errors++; $display("FAIL basic_count got=%0d exp=1", cnt(2)); end
    @(negedge clk);
    checks++; if (ack_dn !== 4'b0000) begin errors++; $display("FAIL basic_ack_one_cycle got=%b exp=0000", ack_dn); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin;
    bit ok;
    int p;
    logic [DW-1:0] d;
    apply_reset();
    for (int n = 0; n < 40; n++) exp_port.push_back(n % 4);
    req_dn = 4'b1111;
    for (int n = 0; n < 40; n++) begin
      wait_ack(20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_timeout transfer=%0d", n); req_dn = '0; return; end
      if (n == 39) req_dn = '0;
      p = exp_port.pop_front();
      d = exp_data.pop_front();
      if (ack_dn !== (4'b0001 << p) || dout_dn !== d) begin
        errors++; $display("FAIL rr_order n=%0d ack=%b dout=%h exp ack=%b dout=%h", n, ack_dn, dout_dn, 4'b0001 << p, d);
      end
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      checks++; if (cnt(i) !== 32'd10) begin errors++; $display("FAIL rr_count port=%0d got=%0d exp=10", i, cnt(i)); end
    end
  endtask

  task automatic test_masking;
    bit ok;
    int p;
    int seq[3] = '{0, 1, 3};
    logic [DW-1:0] d;
    apply_reset();
    for (int n = 0; n < 9; n++) exp_port.push_back(seq[n % 3]);
    port_en = 4'b1011;
    req_dn  = 4'b1111;
    for (int n = 0; n < 9; n++) begin
      wait_ack(20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL mask_timeout transfer=%0d", n); req_dn = '0; return; end
      if (n == 8) req_dn = '0;
      p = exp_port.pop_front();
      d = exp_data.pop_front();
      if (ack_dn !== (4'b0001 << p) || dout_dn !== d) begin
        errors++; $display("FAIL mask_order n=%0d ack=%b dout=%h exp ack=%b dout=%h", n, ack_dn, dout_dn, 4'b0001 << p, d);
      end
    end
    // Withdrawal: port 1 granted, then drops req and is masked while waiting.
    apply_reset();
    stall_cnt = 4;
    req_dn    = 4'b1010;
    @(negedge clk);
    checks++; if (req_up !== 1'b1 || grant_id !== 2'd1)
      begin errors++; $display("FAIL withdraw_grant req_up=%b grant=%0d exp 1 1", req_up, grant_id); end
    req_dn  = 4'b1000;
    port_en = 4'b1101;
    wait_ack(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL withdraw_timeout first"); req_dn = '0; return; end
    port_en = '1;
    d = exp_data.pop_front();
    if (ack_dn !== 4'b0010 || dout_dn !== d)
      begin errors++; $display("FAIL withdraw_ack ack=%b dout=%h exp ack=0010 dout=%h", ack_dn, dout_dn, d); end
    wait_ack(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL withdraw_timeout second"); req_dn = '0; return; end
    req_dn = '0;
    d = exp_data.pop_front();
    if (ack_dn !== 4'b1000 || dout_dn !== d)
      begin errors++; $display("FAIL withdraw_next ack=%b dout=%h exp ack=1000 dout=%h", ack_dn, dout_dn, d); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit pending[NP];
    int issued = 0;
    int acks   = 0;
    int bad    = 0;
    longint sum = 0;
    logic [DW-1:0] d;
    logic [NP-1:0] a;
    apply_reset();
    for (int i = 0; i < NP; i++) pending[i] = 1'b0;
    for (int c = 0; c < 40000 && acks < 5000; c++) begin
      @(negedge clk);
      a = ack_dn;
      if (a !== '0) begin
        d = (exp_data.size() > 0) ? exp_data.pop_front() : 'x;
        if (!$onehot(a) || dout_dn !== d) bad++;
        for (int i = 0; i < NP; i++) begin
          if (a[i]) begin
            if (!pending[i]) bad++;
            pending[i] = 1'b0;
            req_dn[i]  = 1'b0;
            acks++;
          end
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (!a[i] && !pending[i] && issued < 5000 && $urandom_range(3) == 0) begin
          pending[i] = 1'b1;
          req_dn[i]  = 1'b1;
          issued++;
        end
      end
    end
    req_dn = '0;
    repeat (3) @(negedge clk);
    checks++; if (bad != 0)     begin errors++; $display("FAIL b2b_protocol violations=%0d exp=0", bad); end
    checks++; if (acks != 5000) begin errors++; $display("FAIL b2b_acks got=%0d exp=5000", acks); end
    for (int i = 0; i < NP; i++) sum += cnt(i);
    checks++; if (sum != 5000)  begin errors++; $display("FAIL b2b_count_sum got=%0d exp=5000", sum); end
  endtask

  task automatic test_stall;
    bit seen, held, got;
    logic [DW-1:0] d;
    logic [DW-1:0] d0;
    logic [NP*CW-1:0] c0;
    bit ack_seen;
    apply_reset();
    fail_rate = 50;
    req_dn    = 4'b0011;
    for (int n = 0; n < 10; n++) begin
      seen = 1'b0; held = 1'b1; got = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (ack_dn !== '0) begin got = 1'b1; break; end
        if (req_up === 1'b1) seen = 1'b1;
        else if (seen) held = 1'b0;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL stall_timeout transfer=%0d", n); req_dn = '0; fail_rate = 0; return; end
      if (n == 9) req_dn = '0;
      d = exp_data.pop_front();
      if (!held || ack_dn !== (4'b0001 << (n % 2)) || dout_dn !== d)
        begin errors++; $display("FAIL stall_xfer n=%0d held=%0d ack=%b dout=%h exp held=1 ack=%b dout=%h", n, held, ack_dn, dout_dn, 4'b0001 << (n % 2), d); end
    end
    fail_rate = 0;
    repeat (3) @(negedge clk);
    d0 = dout_dn;
    c0 = xfer_count;
    spur_req = 1'b1;
    ack_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack_dn !== '0 || busy !== 1'b0) ack_seen = 1'b1;
    end
    checks++; if (ack_seen)          begin errors++; $display("FAIL spur_activity ack or busy seen exp none"); end
    checks++; if (dout_dn !== d0)    begin errors++; $display("FAIL spur_dout got=%h exp=%h", dout_dn, d0); end
    checks++; if (xfer_count !== c0) begin errors++; $display("FAIL spur_count got=%h exp=%h", xfer_count, c0); end
  endtask

  task automatic test_single;
    bit ok;
    int gap;
    apply_reset();
    req_dn = 4'b0100;
    wait_ack(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout first"); req_dn = '0; return; end
    void'(exp_data.pop_front());
    for (int n = 0; n < 4; n++) begin
      gap = 0;
      ok  = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        gap++;
        if (ack_dn !== '0) begin ok = 1'b1; break; end
      end
      if (n == 3) req_dn = '0;
      if (exp_data.size() > 0) void'(exp_data.pop_front());
      checks++;
      if (!ok || gap != 3 || ack_dn !== 4'b0100)
        begin errors++; $display("FAIL single_period n=%0d gap=%0d ack=%b exp gap=3 ack=0100", n, gap, ack_dn); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [DW-1:0] d;
    apply_reset();
    req_dn = 4'b1111;
    for (int n = 0; n < 2; n++) begin
      wait_ack(20, ok);
      if (!ok) begin checks++; errors++; $display("FAIL rmid_timeout pre n=%0d", n); req_dn = '0; return; end
      void'(exp_data.pop_front());
    end
    stall_cnt = 100;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_up === 1'b1 && ack_dn === '0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_no_wait_up"); req_dn = '0; return; end
    #2 rst = 1'b0;
    #1;
    checks++; if (req_up !== 1'b0 || ack_dn !== '0 || busy !== 1'b0)
      begin errors++; $display("FAIL rmid_outputs req_up=%b ack=%b busy=%b exp 0 0000 0", req_up, ack_dn, busy); end
    checks++; if (xfer_count !== '0 || grant_id !== 2'd3)
      begin errors++; $display("FAIL rmid_state count=%h grant=%0d exp 0 3", xfer_count, grant_id); end
    @(negedge clk);
    stall_cnt = 0;
    exp_data.delete();
    src_data = 32'h100;
    @(negedge clk);
    rst = 1'b1;
    wait_ack(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_timeout post"); req_dn = '0; return; end
    req_dn = '0;
    d = exp_data.pop_front();
    if (ack_dn !== 4'b0001 || dout_dn !== d)
      begin errors++; $display("FAIL rmid_first_grant ack=%b dout=%h exp ack=0001 dout=%h", ack_dn, dout_dn, d); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_masking();
    test_single();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
